// File: rtl/arcade_input_pkg.sv
// Shared types for the arcade input remapper: selector byte layout, coin FSM states.
// Used by arcade_input_map and arcade_coin_pulse.
package arcade_input_pkg;

  typedef struct packed {
    logic       inv;
    logic       zero;
    logic [1:0] player;
    logic [3:0] bit_idx;
  } sel_t;

  localparam logic [7:0] SEL_DEFAULT = 8'h40;

  // Joysticks are padded to this fixed geometry so a selector can index them directly.
  localparam int MAX_PLAYERS = 4;
  localparam int MAX_JOY_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } coin_state_t;

  function automatic logic sel_apply(input sel_t s, input logic src);
    return (s.zero ? 1'b0 : src) ^ s.inv;
  endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// One coin pulse shaper: any press, however short or long, becomes exactly COIN_CYC
// high cycles on coin_s; a new pulse needs a release first.
//
// state | meaning
// IDLE  | waiting for a coin press
// PULSE | coin_s high, counting down COIN_CYC cycles
// HOLD  | pulse done, waiting for the coin to be released
module arcade_coin_pulse
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYC = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_in,
  output logic coin_s
);

  localparam int CNT_W = (COIN_CYC > 1) ? $clog2(COIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_CYC - 1);

  coin_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && coin_in)
        cnt <= CNT_LOAD;
      else if (state == PULSE && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (coin_in)    state_nxt = PULSE;
      PULSE:   if (cnt == '0)  state_nxt = HOLD;
      HOLD:    if (!coin_in)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    coin_s = (state == PULSE);
  end

endmodule

// File: rtl/arcade_input_map.sv
// Table-driven joystick-to-port remapper with coin shaping, pause toggle and DIP store.
// Optional autofire gating is built when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_map
  import arcade_input_pkg::*;
#(
  parameter int         NUM_PLAYERS = 2,
  parameter int         JOY_W       = 16,
  parameter int         NUM_PORTS   = 4,
  parameter int         NUM_DSW     = 8,
  parameter logic [7:0] MAP_INDEX   = 8'd2,
  parameter logic [7:0] DSW_INDEX   = 8'd254,
  parameter int         COIN_BIT    = 7,
  parameter int         PAUSE_BIT   = 8,
  parameter int         COIN_CYC    = 16
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  ,
  parameter int         AF_HALF     = 4096
`endif
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic [NUM_PLAYERS*JOY_W-1:0] joy,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [JOY_W-1:0]             autofire_mask,
`endif
  input  logic                         ioctl_download,
  input  logic                         ioctl_wr,
  input  logic [26:0]                  ioctl_addr,
  input  logic [15:0]                  ioctl_dout,
  input  logic [7:0]                   ioctl_index,
  output logic [NUM_PORTS*8-1:0]       port_out,
  output logic [NUM_DSW*8-1:0]         dsw,
  output logic                         pause,
  output logic                         map_valid
);

  localparam int NUM_SEL = NUM_PORTS * 8;
  localparam int SEL_AW  = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
  localparam int DSW_AW  = (NUM_DSW > 1) ? $clog2(NUM_DSW) : 1;
  localparam logic [26:0] SEL_LIMIT = 27'(NUM_SEL);
  localparam logic [26:0] DSW_LIMIT = 27'(NUM_DSW);

  sel_t                         sel [NUM_SEL];
  logic [NUM_PLAYERS*JOY_W-1:0] joy_q;
  logic [NUM_PLAYERS*JOY_W-1:0] joy_m;
  logic [NUM_PLAYERS-1:0]       coin_s;
  logic [MAX_PLAYERS*MAX_JOY_W-1:0] joy_pad;
  logic [MAX_PLAYERS-1:0]       coin_pad;
  logic [NUM_SEL-1:0]           map_next;
  logic                         map_window;
  logic                         dl_map_q;
  logic                         pause_prev;
  logic                         map_wr;
  logic                         dsw_wr;
  logic                         unused_dout;

  assign unused_dout = ^ioctl_dout[15:8];
  assign map_window  = ioctl_download && (ioctl_index == MAP_INDEX);
  assign map_wr      = ioctl_wr && (ioctl_index == MAP_INDEX) && (ioctl_addr < SEL_LIMIT);
  assign dsw_wr      = ioctl_wr && (ioctl_index == DSW_INDEX) && (ioctl_addr < DSW_LIMIT);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SEL; i++) sel[i] <= sel_t'(SEL_DEFAULT);
    end else if (map_wr) begin
      for (int i = 0; i < NUM_SEL; i++)
        if (ioctl_addr[SEL_AW-1:0] == SEL_AW'(i)) sel[i] <= sel_t'(ioctl_dout[7:0]);
    end
  end

  // DIP bytes deliberately survive a map download; only reset clears them.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dsw <= '0;
    end else if (dsw_wr) begin
      for (int n = 0; n < NUM_DSW; n++)
        if (ioctl_addr[DSW_AW-1:0] == DSW_AW'(n)) dsw[n*8 +: 8] <= ioctl_dout[7:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_map_q  <= 1'b0;
      map_valid <= 1'b0;
    end else begin
      dl_map_q <= map_window;
      if (map_window && !dl_map_q)
        map_valid <= 1'b0;
      else if (dl_map_q && !ioctl_download)
        map_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) joy_q <= '0;
    else          joy_q <= joy;
  end

  // Coin FSMs run from raw joy so the pulse lines up with joy_q in stage 2.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    arcade_coin_pulse #(.COIN_CYC(COIN_CYC)) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .coin_in (joy[p*JOY_W + COIN_BIT]),
      .coin_s  (coin_s[p])
    );
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AF_W = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
  logic [AF_W-1:0] af_cnt;
  logic            af_phase;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_W'(AF_HALF - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + AF_W'(1);
    end
  end

  always_comb begin
    joy_m = joy_q;
    for (int p = 0; p < NUM_PLAYERS; p++)
      for (int b = 0; b < JOY_W; b++)
        if (b != COIN_BIT && b != PAUSE_BIT && autofire_mask[b])
          joy_m[p*JOY_W + b] = joy_q[p*JOY_W + b] & af_phase;
  end
`else
  assign joy_m = joy_q;
`endif

  for (genvar p = 0; p < MAX_PLAYERS; p++) begin : g_pad_p
    if (p < NUM_PLAYERS) begin : g_coin_on
      assign coin_pad[p] = coin_s[p];
    end else begin : g_coin_off
      assign coin_pad[p] = 1'b0;
    end
    for (genvar b = 0; b < MAX_JOY_W; b++) begin : g_pad_b
      if (p < NUM_PLAYERS && b < JOY_W) begin : g_on
        assign joy_pad[p*MAX_JOY_W + b] = joy_m[p*JOY_W + b];
      end else begin : g_off
        assign joy_pad[p*MAX_JOY_W + b] = 1'b0;
      end
    end
  end

  function automatic logic sel_src(input sel_t s,
                                   input logic [MAX_PLAYERS*MAX_JOY_W-1:0] jp,
                                   input logic [MAX_PLAYERS-1:0] cp);
    sel_src = 1'b0;
    if (int'(s.player) < NUM_PLAYERS && int'(s.bit_idx) < JOY_W) begin
      if (int'(s.bit_idx) == COIN_BIT) sel_src = cp[s.player];
      else                             sel_src = jp[{s.player, s.bit_idx}];
    end
  endfunction

  always_comb begin
    map_next = '0;
    for (int k = 0; k < NUM_SEL; k++)
      map_next[k] = sel_apply(sel[k], sel_src(sel[k], joy_pad, coin_pad));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        port_out <= '0;
    else if (map_window) port_out <= '0;
    else                 port_out <= map_next;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pause_prev <= 1'b0;
      pause      <= 1'b0;
    end else begin
      pause_prev <= joy_q[PAUSE_BIT];
      if (joy_q[PAUSE_BIT] && !pause_prev) pause <= ~pause;
    end
  end

endmodule

// File: tb/tb_arcade_input_map.sv
// Scoreboard bench for arcade_input_map: stimulus queues timed expectations,
// a negedge monitor compares them against the outputs when they fall due.
module tb_arcade_input_map;

  localparam int K_PORT = 0;
  localparam int K_BIT  = 1;
  localparam int K_MV   = 2;
  localparam int K_DSW  = 3;
  localparam int K_PAU  = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] joy = '0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [15:0] autofire_mask = '0;
`endif
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic [31:0] port_out;
  logic [63:0] dsw;
  logic        pause;
  logic        map_valid;

  arcade_input_map dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .joy            (joy),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire_mask  (autofire_mask),
`endif
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .port_out       (port_out),
    .dsw            (dsw),
    .pause          (pause),
    .map_valid      (map_valid)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          due;
    int          kind;
    int          idx;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    int i;
    logic [63:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          K_PORT:  act = {32'b0, port_out};
          K_BIT:   act = 64'(port_out[sb[i].idx]);
          K_MV:    act = 64'(map_valid);
          K_DSW:   act = dsw;
          default: act = 64'(pause);
        endcase
        n_checks++;
        if (sb[i].due < cyc || act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d (due %0d): got %0h expected %0h",
                   sb[i].name, cyc, sb[i].due, act, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_at(input int dly, input int kind, input int idx,
                           input logic [63:0] exp, input string name);
    chk_t c;
    c.due = cyc + dly; c.kind = kind; c.idx = idx; c.exp = exp; c.name = name;
    sb.push_back(c);
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    ioctl_addr = 27'(addr);
    ioctl_dout = {8'hEE, data};
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    tick(3);
    n_checks++;
    if (port_out !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_reset_port: got %0h", port_out);
    end
    n_checks++;
    if (map_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_reset_map_valid: got %0b", map_valid);
    end
    expect_at(1, K_PORT, 0, 64'h0, "reset_port");
    expect_at(1, K_MV,   0, 64'h0, "reset_map_valid");
    expect_at(1, K_PAU,  0, 64'h0, "reset_pause");
    expect_at(1, K_DSW,  0, 64'h0, "reset_dsw");
    tick(1);
    reset_n = 1'b1;
    joy[4] = 1'b1;
    expect_at(3, K_PORT, 0, 64'h0, "default_sel_port");
    tick(4);

    // Map download: sel0=p0 b4, sel9=~p1 b3, sel5=coin p0
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick(1);
    wr(0, 8'h04);
    wr(9, 8'h93);
    wr(5, 8'h07);
    expect_at(1, K_MV,   0, 64'h0, "map_valid_in_window");
    expect_at(2, K_PORT, 0, 64'h0, "port_forced_in_window");
    tick(3);
    ioctl_download = 1'b0;
    expect_at(1, K_MV,   0, 64'h1, "map_valid_after_dl");
    expect_at(2, K_PORT, 0, 64'h201, "map_first");
    tick(4);

    joy[19] = 1'b1;
    expect_at(1, K_PORT, 0, 64'h201, "invert_latency_1");
    expect_at(2, K_PORT, 0, 64'h001, "invert_latency_2");
    tick(3);
    joy[19] = 1'b0;
    joy[4]  = 1'b0;
    expect_at(2, K_PORT, 0, 64'h200, "invert_release");
    tick(4);

    // 1-cycle coin press -> 16 cycles high on port bit 5
    joy[7] = 1'b1;
    expect_at(1, K_BIT, 5, 64'h0, "coin_short_pre");
    for (int d = 2; d <= 17; d++) expect_at(d, K_BIT, 5, 64'h1, "coin_short_hi");
    expect_at(18, K_BIT, 5, 64'h0, "coin_short_end");
    tick(1);
    joy[7] = 1'b0;
    tick(25);

    // 100-cycle press -> single 16-cycle pulse
    joy[7] = 1'b1;
    expect_at(2,  K_BIT, 5, 64'h1, "coin_long_start");
    expect_at(17, K_BIT, 5, 64'h1, "coin_long_last");
    expect_at(18, K_BIT, 5, 64'h0, "coin_long_end");
    expect_at(60, K_BIT, 5, 64'h0, "coin_long_held");
    expect_at(99, K_BIT, 5, 64'h0, "coin_long_held_late");
    tick(100);
    joy[7] = 1'b0;
    tick(4);
    joy[7] = 1'b1;
    expect_at(2,  K_BIT, 5, 64'h1, "coin_repress_start");
    expect_at(17, K_BIT, 5, 64'h1, "coin_repress_last");
    expect_at(18, K_BIT, 5, 64'h0, "coin_repress_end");
    tick(1);
    joy[7] = 1'b0;
    tick(25);

    // DIP download, addrs 8 and 9 out of range
    ioctl_index = 8'd254;
    ioctl_download = 1'b1;
    tick(1);
    for (int a = 0; a < 10; a++) wr(a, 8'hA0 + 8'(a));
    expect_at(1, K_MV, 0, 64'h1, "map_valid_during_dsw");
    ioctl_download = 1'b0;
    tick(2);
    n_checks++;
    if (dsw !== 64'hA7A6A5A4A3A2A1A0) begin
      n_fail++;
      $display("FAIL direct_dsw_load: got %0h", dsw);
    end
    expect_at(1, K_DSW, 0, 64'hA7A6A5A4A3A2A1A0, "dsw_load");
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick(1);
    wr(0, 8'h04);
    ioctl_download = 1'b0;
    tick(2);
    expect_at(1, K_DSW, 0, 64'hA7A6A5A4A3A2A1A0, "dsw_kept");
    expect_at(1, K_MV,  0, 64'h1, "map_valid_redl");
    tick(3);

    // Pause toggles on each press of player-0 bit 8
    joy[8] = 1'b1;
    expect_at(1, K_PAU, 0, 64'h0, "pause_pre");
    expect_at(2, K_PAU, 0, 64'h1, "pause_on");
    tick(2);
    joy[8] = 1'b0;
    tick(3);
    joy[8] = 1'b1;
    expect_at(2, K_PAU, 0, 64'h0, "pause_off");
    tick(2);
    joy[8] = 1'b0;
    tick(3);
    joy[8] = 1'b1;
    expect_at(2, K_PAU, 0, 64'h1, "pause_on_again");
    tick(2);
    joy[8] = 1'b0;
    tick(3);

    // Async reset mid coin pulse
    joy[7] = 1'b1;
    tick(1);
    joy[7] = 1'b0;
    tick(3);
    expect_at(0, K_BIT, 5, 64'h1, "coin_before_reset");
    expect_at(0, K_PAU, 0, 64'h1, "pause_before_reset");
    tick(1);
    reset_n = 1'b0;
    expect_at(0, K_PORT, 0, 64'h0, "async_reset_port");
    expect_at(0, K_PAU,  0, 64'h0, "async_reset_pause");
    expect_at(0, K_MV,   0, 64'h0, "async_reset_map_valid");
    tick(2);
    n_checks++;
    if (port_out !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_async_reset_port: got %0h", port_out);
    end
    n_checks++;
    if (pause !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_async_reset_pause: got %0b", pause);
    end
    n_checks++;
    if (map_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_async_reset_map_valid: got %0b", map_valid);
    end
    reset_n = 1'b1;
    tick(2);

    // Reset in the middle of a map download
    joy = '0;
    joy[4] = 1'b1;
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick(1);
    wr(0, 8'h04);
    wr(1, 8'h04);
    wr(2, 8'h04);
    expect_at(1, K_PORT, 0, 64'h0, "dl_port_forced");
    expect_at(1, K_MV,   0, 64'h0, "dl_map_valid_low");
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    wr(3, 8'h04);
    expect_at(1, K_PORT, 0, 64'h0, "dl_port_forced_after_rst");
    expect_at(1, K_MV,   0, 64'h0, "dl_map_valid_after_rst");
    tick(2);
    ioctl_download = 1'b0;
    expect_at(1, K_MV,   0, 64'h1, "dl_map_valid_close");
    expect_at(2, K_PORT, 0, 64'h08, "dl_table_after_rst");
    tick(6);

    foreach (sb[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked, due %0d at cyc %0d", sb[i].name, sb[i].due, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
